fir_tap_accum: RTL and testbench

Accumulates the per-tap complex products from the conjugate multiplier into one FIR output sample, using a widened accumulator. At the end of each output frame, marked by `in_last`, it applies a rounded arithmetic right shift and saturates the result back to `FIR_DATA_SAMPLE`. It sits directly downstream of the FIR complex multiplier and presents results through a one-entry valid/ready output register.

---
 rtl/fir_pkg.sv | 26 ++
 rtl/fir_acc_rnd_sat.sv | 46 ++++
 rtl/fir_tap_accum.sv | 120 ++++++++++++
 tb/tb_fir_tap_accum.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR tap-accumulation path.
// The sample width can be overridden with a define before this file is compiled.
`ifndef FIR_DATA_WIDTH
`define FIR_DATA_WIDTH 16
`endif

package fir_pkg;

   localparam int FIR_DATA_WIDTH = `FIR_DATA_WIDTH;
   localparam int FIR_ACC_GUARD  = 8;
   localparam int FIR_ACC_WIDTH  = FIR_DATA_WIDTH + FIR_ACC_GUARD;
   localparam int FIR_SHIFT_W    = $clog2(FIR_ACC_WIDTH);

   typedef logic [FIR_SHIFT_W-1:0] FIR_SHIFT;

   typedef struct packed {
      logic signed [FIR_DATA_WIDTH-1:0] data_r;
      logic signed [FIR_DATA_WIDTH-1:0] data_i;
   } FIR_DATA_SAMPLE;

   typedef struct packed {
      logic signed [FIR_ACC_WIDTH-1:0] data_r;
      logic signed [FIR_ACC_WIDTH-1:0] data_i;
   } FIR_ACC_SAMPLE;

endpackage

// File: rtl/fir_acc_rnd_sat.sv
// Combinational round-half-up arithmetic right shift of one accumulator
// component, then saturation to the output sample width.
module fir_acc_rnd_sat
   import fir_pkg::*;
#(
   parameter int ACC_W      = FIR_ACC_WIDTH,
   parameter int DATA_WIDTH = FIR_DATA_WIDTH
) (
   input  logic signed [ACC_W-1:0]      s,
   input  FIR_SHIFT                     shift,
   output logic signed [DATA_WIDTH-1:0] r,
   output logic                         clip
);

   // One extra bit so adding the rounding half can never overflow.
   localparam int EXT_W = ACC_W + 1;
   localparam logic signed [EXT_W-1:0] MAX_V =
      {{(EXT_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [EXT_W-1:0] MIN_V =
      {{(EXT_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   logic signed [EXT_W-1:0] s_ext;
   logic signed [EXT_W-1:0] half;
   logic signed [EXT_W-1:0] rounded;
   logic signed [EXT_W-1:0] shifted;

   always_comb begin
      s_ext = {s[ACC_W-1], s};
      half  = '0;
      if (shift != '0) begin
         half = EXT_W'(1) << (shift - FIR_SHIFT'(1));
      end
      rounded = s_ext + half;
      shifted = rounded >>> shift;
      clip    = 1'b0;
      r       = shifted[DATA_WIDTH-1:0];
      if (shifted > MAX_V) begin
         r    = MAX_V[DATA_WIDTH-1:0];
         clip = 1'b1;
      end else if (shifted < MIN_V) begin
         r    = MIN_V[DATA_WIDTH-1:0];
         clip = 1'b1;
      end
   end

endmodule

// File: rtl/fir_tap_accum.sv
// Sums per-tap complex products into one FIR output sample with a widened,
// saturating accumulator; emits a rounded, saturated result on in_last.
module fir_tap_accum
   import fir_pkg::*;
#(
   parameter int DATA_WIDTH = `FIR_DATA_WIDTH,
   parameter int ACC_GUARD  = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  FIR_DATA_SAMPLE in_data,
   input  logic           in_valid,
   input  logic           in_last,
   output logic           in_ready,
   input  FIR_SHIFT       shift,
   output FIR_DATA_SAMPLE out_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           out_sat
);

   localparam int ACC_W = DATA_WIDTH + ACC_GUARD;
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic signed [ACC_W-1:0]      acc_q [2];
   logic signed [ACC_W-1:0]      acc_d [2];
   logic                         first_q, first_d;
   logic                         acc_sat_q, acc_sat_d;
   FIR_DATA_SAMPLE               out_data_q, out_data_d;
   logic                         out_valid_q, out_valid_d;
   logic                         out_sat_q, out_sat_d;

   logic signed [ACC_W-1:0]      in_comp [2];
   logic signed [ACC_W-1:0]      sum_sat [2];
   logic                         ovf [2];
   logic signed [DATA_WIDTH-1:0] rnd_r [2];
   logic                         clip [2];
   logic                         accept;
   logic                         acc_sat_next;

   assign in_comp[0] = ACC_W'(in_data.data_r);
   assign in_comp[1] = ACC_W'(in_data.data_i);

   // Index 0 is the real component, index 1 the imaginary one.
   for (genvar gi = 0; gi < 2; gi++) begin : g_comp
      logic signed [ACC_W:0] base_w;
      logic signed [ACC_W:0] sum_w;

      assign base_w      = first_q ? '0 : {acc_q[gi][ACC_W-1], acc_q[gi]};
      assign sum_w       = base_w + {in_comp[gi][ACC_W-1], in_comp[gi]};
      assign ovf[gi]     = sum_w[ACC_W] ^ sum_w[ACC_W-1];
      assign sum_sat[gi] = ovf[gi] ? (sum_w[ACC_W] ? ACC_MIN : ACC_MAX)
                                   : sum_w[ACC_W-1:0];

      fir_acc_rnd_sat #(
         .ACC_W      (ACC_W),
         .DATA_WIDTH (DATA_WIDTH)
      ) u_rnd_sat (
         .s     (sum_sat[gi]),
         .shift (shift),
         .r     (rnd_r[gi]),
         .clip  (clip[gi])
      );
   end

   assign in_ready     = !out_valid_q || out_ready;
   assign accept       = in_valid && in_ready;
   assign acc_sat_next = (first_q ? 1'b0 : acc_sat_q) | ovf[0] | ovf[1];

   always_comb begin
      acc_d       = acc_q;
      first_d     = first_q;
      acc_sat_d   = acc_sat_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_sat_d   = out_sat_q;
      if (out_ready) begin
         out_valid_d = 1'b0;
      end
      if (accept) begin
         acc_d[0] = sum_sat[0];
         acc_d[1] = sum_sat[1];
         if (in_last) begin
            out_data_d.data_r = rnd_r[0];
            out_data_d.data_i = rnd_r[1];
            out_valid_d       = 1'b1;
            out_sat_d         = acc_sat_next | clip[0] | clip[1];
            first_d           = 1'b1;
            acc_sat_d         = 1'b0;
         end else begin
            first_d   = 1'b0;
            acc_sat_d = acc_sat_next;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q       <= '{default: '0};
         first_q     <= 1'b1;
         acc_sat_q   <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_sat_q   <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         first_q     <= first_d;
         acc_sat_q   <= acc_sat_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_sat_q   <= out_sat_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_fir_tap_accum.sv
// Self-checking bench for fir_tap_accum: vector table, directed handshake and
// reset sequences, then randomized frames against a frame-level model.
module tb_fir_tap_accum;
   import fir_pkg::*;

   localparam int DW    = 16;
   localparam int ACC_W = 24;

   logic           clk = 1'b0;
   logic           rst;
   FIR_DATA_SAMPLE in_data;
   logic           in_valid;
   logic           in_last;
   logic           in_ready;
   FIR_SHIFT       shift;
   FIR_DATA_SAMPLE out_data;
   logic           out_valid;
   logic           out_ready;
   logic           out_sat;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fir_tap_accum #(
      .DATA_WIDTH (DW),
      .ACC_GUARD  (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .shift     (shift),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sat   (out_sat)
   );

   typedef struct {
      int ar; int ai; int br; int bi; int n; int sh;
      int er; int ei; bit es;
   } vec_t;

   typedef struct {
      int r; int i; bit last; int sh;
   } beat_t;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   // Frame-level reference: saturating sum, round-half-up shift, clamp.
   function automatic void model_comp(input int vals[$], input int sh,
                                      output int r, output bit sat);
      longint acc  = 0;
      longint amax = (longint'(1) << (ACC_W-1)) - 1;
      longint amin = -(longint'(1) << (ACC_W-1));
      sat = 1'b0;
      foreach (vals[k]) begin
         acc = acc + vals[k];
         if (acc > amax) begin acc = amax; sat = 1'b1; end
         if (acc < amin) begin acc = amin; sat = 1'b1; end
      end
      if (sh > 0) acc = (acc + (longint'(1) << (sh-1))) >>> sh;
      if (acc > 32767) begin r = 32767; sat = 1'b1; end
      else if (acc < -32768) begin r = -32768; sat = 1'b1; end
      else r = int'(acc);
   endfunction

   task automatic drive(input int r, input int i, input bit last, input int sh);
      in_data.data_r = DW'(r);
      in_data.data_i = DW'(i);
      in_last        = last;
      shift          = FIR_SHIFT'(sh);
      in_valid       = 1'b1;
   endtask

   task automatic push(input int r, input int i, input bit last, input int sh);
      int w = 0;
      drive(r, i, last, sh);
      #1;
      while (!in_ready && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      if (!in_ready) begin
         total++; bad++;
         $display("FAIL push_timeout: in_ready got 0, expected 1");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic check_out(input string name, input int er, input int ei, input bit es);
      check({name, "_valid"}, int'(out_valid), 1);
      check({name, "_r"}, int'(out_data.data_r), er);
      check({name, "_i"}, int'(out_data.data_i), ei);
      check({name, "_sat"}, int'(out_sat), int'(es));
   endtask

   vec_t  vecs[9];
   beat_t stream[$];
   int    exp_r[$];
   int    exp_i[$];
   bit    exp_s[$];
   int    cur_r[$];
   int    cur_i[$];
   int    vals[3];

   initial begin
      rst       = 1'b1;
      in_data   = '0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      shift     = '0;
      out_ready = 1'b1;

      vecs[0] = '{100, -50, 100, -50, 4, 0, 400, -200, 1'b0};
      vecs[1] = '{3, -3, 2, -2, 2, 1, 3, -2, 1'b0};
      vecs[2] = '{32767, -32768, 32767, -32768, 300, 0, 32767, -32768, 1'b1};
      vecs[3] = '{1, 1, 1, 1, 1, 0, 1, 1, 1'b0};
      vecs[4] = '{-5, 5, -5, 5, 1, 1, -2, 3, 1'b0};
      vecs[5] = '{-6, 6, -6, 6, 1, 2, -1, 2, 1'b0};
      vecs[6] = '{30000, -30000, 30000, -30000, 2, 0, 32767, -32768, 1'b1};
      vecs[7] = '{1000, -1000, 1000, -1000, 3, 4, 188, -187, 1'b0};
      vecs[8] = '{32767, 32767, 32767, 32767, 300, 8, 32767, 32767, 1'b1};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_out_data", int'(out_data), 0);
      check("reset_out_sat", int'(out_sat), 0);
      check("reset_in_ready", int'(in_ready), 1);

      // Table-driven frames.
      for (int v = 0; v < 9; v++) begin
         for (int k = 0; k < vecs[v].n; k++) begin
            if (k == 0) push(vecs[v].ar, vecs[v].ai, (k == vecs[v].n-1), vecs[v].sh);
            else        push(vecs[v].br, vecs[v].bi, (k == vecs[v].n-1), vecs[v].sh);
         end
         check_out($sformatf("vec%0d", v), vecs[v].er, vecs[v].ei, vecs[v].es);
      end
      @(posedge clk); #1;
      check("idle_after_pop", int'(out_valid), 0);

      // Backpressure: result held, input stalled, then resumes cleanly.
      push(5, 5, 1'b1, 0);
      out_ready = 1'b0;
      drive(7, 0, 1'b0, 0);
      #1;
      check("bp_in_ready_low", int'(in_ready), 0);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         check("bp_hold_valid", int'(out_valid), 1);
         check("bp_hold_data", int'(out_data.data_r), 5);
         check("bp_in_ready", int'(in_ready), 0);
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", int'(in_ready), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_popped", int'(out_valid), 0);
      push(8, 0, 1'b1, 0);
      check_out("bp_resume", 15, 0, 1'b0);
      @(posedge clk); #1;
      check("bp_no_dup", int'(out_valid), 0);

      // Back-to-back single-beat frames.
      vals = '{10, 20, 30};
      for (int k = 0; k < 3; k++) begin
         drive(vals[k], 0, 1'b1, 0);
         @(posedge clk); #1;
         check_out($sformatf("b2b%0d", k), vals[k], 0, 1'b0);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(posedge clk); #1;
      check("b2b_drain", int'(out_valid), 0);

      // Reset in mid-frame discards the partial sum.
      push(7, 7, 1'b0, 0);
      push(7, 7, 1'b0, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_mid_valid", int'(out_valid), 0);
      check("rst_mid_ready", int'(in_ready), 1);
      push(1, 0, 1'b1, 0);
      check_out("rst_mid_frame", 1, 0, 1'b0);
      @(posedge clk); #1;

      // Randomized frames with random valid/ready patterns.
      for (int f = 0; f < 40; f++) begin
         int len = (f % 8 == 7) ? int'($urandom_range(100, 400)) : int'($urandom_range(1, 6));
         for (int k = 0; k < len; k++) begin
            beat_t b;
            b.r    = int'($signed(16'($urandom)));
            b.i    = int'($signed(16'($urandom)));
            b.last = (k == len-1);
            b.sh   = int'($urandom_range(0, 12));
            stream.push_back(b);
         end
      end
      begin
         int idx = 0;
         int cyc = 0;
         while ((idx < stream.size() || exp_r.size() > 0) && cyc < 20000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (idx < stream.size() && $urandom_range(0, 4) != 0)
               drive(stream[idx].r, stream[idx].i, stream[idx].last, stream[idx].sh);
            else
               in_valid = 1'b0;
            @(negedge clk);
            if (out_valid && !out_ready) check("rnd_stall_in_ready", int'(in_ready), 0);
            if (out_valid && out_ready) begin
               if (exp_r.size() == 0) begin
                  total++; bad++;
                  $display("FAIL rnd_extra_output: got out_valid 1, expected 0");
               end else begin
                  check("rnd_r", int'(out_data.data_r), exp_r.pop_front());
                  check("rnd_i", int'(out_data.data_i), exp_i.pop_front());
                  check("rnd_sat", int'(out_sat), int'(exp_s.pop_front()));
               end
            end
            if (in_valid && in_ready) begin
               cur_r.push_back(stream[idx].r);
               cur_i.push_back(stream[idx].i);
               if (stream[idx].last) begin
                  int rr, ri;
                  bit sr, si;
                  model_comp(cur_r, stream[idx].sh, rr, sr);
                  model_comp(cur_i, stream[idx].sh, ri, si);
                  exp_r.push_back(rr);
                  exp_i.push_back(ri);
                  exp_s.push_back(sr | si);
                  cur_r.delete();
                  cur_i.delete();
               end
               idx++;
            end
            @(posedge clk); #1;
            cyc++;
         end
         in_valid = 1'b0;
         if (cyc >= 20000) begin
            total++; bad++;
            $display("FAIL rnd_timeout: pending results %0d, expected 0", exp_r.size());
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
